dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 34 +++
 rtl/dmem_out_fifo.sv | 63 ++++++
 rtl/dmem_responder.sv | 120 ++++++++++++
 tb/tb_dmem_responder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: MMIO offsets, STATUS
// layout and the address-decode classes.
package dmem_pkg;

  localparam logic [31:0] MMIO_PUSH   = 32'h0;
  localparam logic [31:0] MMIO_STATUS = 32'h4;
  localparam logic [31:0] MMIO_CYCLE  = 32'h8;

  localparam int ST_EMPTY  = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_OVF    = 2;
  localparam int ST_CNT_LO = 4;
  localparam int ST_CNT_HI = 8;

  typedef enum logic [2:0] {
    DEC_RAM,
    DEC_PUSH,
    DEC_STATUS,
    DEC_CYCLE,
    DEC_ERR
  } dec_e;

  function automatic logic [31:0] pack_status(input logic empty, input logic full,
                                              input logic ovf, input logic [4:0] cnt);
    logic [31:0] st;
    st = '0;
    st[ST_EMPTY] = empty;
    st[ST_FULL]  = full;
    st[ST_OVF]   = ovf;
    st[ST_CNT_HI:ST_CNT_LO] = cnt;
    return st;
  endfunction

endpackage

// File: rtl/dmem_out_fifo.sv
// Synchronous output FIFO. A push into a full FIFO is accepted only when the
// head is popped at the same edge; otherwise it is dropped and flagged.
module dmem_out_fifo
  import dmem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [W-1:0]           data_i,
  input  logic                   ready_i,
  output logic                   valid_o,
  output logic [W-1:0]           data_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic                   drop_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pop, accept;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign valid_o = ~empty_o;
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  assign pop    = ready_i & ~empty_o;
  // When full, the slot being written is the head that leaves at this edge.
  assign accept = push_i & (~full_o | pop);
  assign drop_o = push_i & full_o & ~pop;

  always_comb begin
    wr_d  = accept ? wr_q + PW'(1) : wr_q;
    rd_d  = pop ? rd_q + PW'(1) : rd_q;
    cnt_d = cnt_q + CW'(accept) - CW'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && accept) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus MMIO FIFO/STATUS/CYCLE with zero-latency reads.
// Optional cycle counter at MMIO_BASE+8 is built when DMEM_CYCLE_CNT_EN is defined.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH      = 1024,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        addr_err
);

  localparam int          AW        = $clog2(DEPTH);
  localparam int          FCW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH) * 33'd4;

  dec_e           dec;
  logic           access, err, push, status_wr;
  logic [31:0]    ram_q [DEPTH];
  logic           ovf_q, ovf_d;
  logic           aerr_q, aerr_d;
  logic           fifo_empty, fifo_full, fifo_drop;
  logic [FCW-1:0] fifo_count;
  logic [31:0]    status, cycle_val;

  always_comb begin
    dec = DEC_ERR;
    if (mem_addr[1:0] == 2'b00) begin
      if ({1'b0, mem_addr} < RAM_BYTES)              dec = DEC_RAM;
      else if (mem_addr == MMIO_BASE + MMIO_PUSH)   dec = DEC_PUSH;
      else if (mem_addr == MMIO_BASE + MMIO_STATUS) dec = DEC_STATUS;
      else if (mem_addr == MMIO_BASE + MMIO_CYCLE)  dec = DEC_CYCLE;
    end
  end

  assign access    = mem_ren | mem_wen;
  assign err       = access & (dec == DEC_ERR);
  assign push      = mem_wen & (dec == DEC_PUSH);
  assign status_wr = mem_wen & (dec == DEC_STATUS);

  dmem_out_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push),
    .data_i  (mem_wdata),
    .ready_i (out_ready),
    .valid_o (out_valid),
    .data_o  (out_data),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .drop_o  (fifo_drop),
    .count_o (fifo_count)
  );

  // RAM contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_wen && dec == DEC_RAM) ram_q[mem_addr[AW+1:2]] <= mem_wdata;
  end

  always_comb begin
    ovf_d  = ovf_q;
    if (status_wr)      ovf_d = 1'b0;
    else if (fifo_drop) ovf_d = 1'b1;
    aerr_d = aerr_q | err;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_q  <= 1'b0;
      aerr_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      aerr_q <= aerr_d;
    end
  end

  assign addr_err = aerr_q;
  assign status   = pack_status(fifo_empty, fifo_full, ovf_q, 5'(fifo_count));

`ifdef DMEM_CYCLE_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 32'd1;
    if (mem_wen && dec == DEC_CYCLE) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cycle_val = cnt_q;
`else
  assign cycle_val = '0;
`endif

  always_comb begin
    mem_rdata = '0;
    if (mem_ren) begin
      case (dec)
        DEC_RAM:    mem_rdata = ram_q[mem_addr[AW+1:2]];
        DEC_STATUS: mem_rdata = status;
        DEC_CYCLE:  mem_rdata = cycle_val;
        default:    mem_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised and directed bench for dmem_responder against a queue-based reference model.
module tb_dmem_responder;

  localparam int          DEPTH = 1024;
  localparam int          FD    = 4;
  localparam logic [31:0] B     = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_ren = 1'b0, mem_wen = 1'b0, out_ready = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [31:0] mem_rdata, out_data;
  logic        out_valid, addr_err;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .FIFO_DEPTH(FD), .MMIO_BASE(B)) dut (
    .clk(clk), .rst(rst), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .addr_err(addr_err)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] ram_m [int];
  logic [31:0] exp_q [$];
  logic        ovf_m, aerr_m;
  logic [31:0] cyc_m;

  logic [31:0] obs_rd, obs_d, exp_rd, exp_d;
  logic        obs_v, obs_ae, exp_v, exp_ae;

  function automatic bit is_err(input logic [31:0] a);
    if (a[1:0] != 2'b00) return 1'b1;
    if (a < DEPTH * 4) return 1'b0;
    if (a == B || a == B + 4 || a == B + 8) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_rdata(input logic ren, input logic [31:0] a);
    logic [31:0] st;
    if (!ren || is_err(a)) return 32'h0;
    if (a < DEPTH * 4) return ram_m.exists(int'(a >> 2)) ? ram_m[int'(a >> 2)] : 32'h0;
    if (a == B + 4) begin
      st = 32'h0;
      st[0] = (exp_q.size() == 0);
      st[1] = (exp_q.size() == FD);
      st[2] = ovf_m;
      st[8:4] = 5'(exp_q.size());
      return st;
    end
`ifdef DMEM_CYCLE_CNT_EN
    if (a == B + 8) return cyc_m;
`endif
    return 32'h0;
  endfunction

  task automatic model_step(input logic ren, input logic wen, input logic [31:0] a,
                            input logic [31:0] wd, input logic rdy);
    bit pop, err;
    pop = rdy && (exp_q.size() > 0);
    err = (ren || wen) && is_err(a);
    if (pop) void'(exp_q.pop_front());
    if (wen && !err) begin
      if (a < DEPTH * 4) ram_m[int'(a >> 2)] = wd;
      else if (a == B) begin
        if (exp_q.size() == FD) ovf_m = 1'b1;
        else exp_q.push_back(wd);
      end
      else if (a == B + 4) ovf_m = 1'b0;
    end
    if (err) aerr_m = 1'b1;
    if (wen && a == B + 8) cyc_m = 32'h0;
    else cyc_m = cyc_m + 32'd1;
  endtask

  // One bus cycle: drive, sample before the edge, advance the model at the edge.
  task automatic step(input logic ren, input logic wen, input logic [31:0] a,
                      input logic [31:0] wd, input logic rdy);
    mem_ren = ren; mem_wen = wen; mem_addr = a; mem_wdata = wd; out_ready = rdy;
    @(negedge clk);
    obs_rd = mem_rdata; obs_v = out_valid; obs_d = out_data; obs_ae = addr_err;
    exp_rd = model_rdata(ren, a);
    exp_v  = (exp_q.size() != 0);
    exp_d  = exp_v ? exp_q[0] : 32'h0;
    exp_ae = aerr_m;
    model_step(ren, wen, a, wd, rdy);
    @(posedge clk); #1;
    mem_ren = 1'b0; mem_wen = 1'b0;
  endtask

  task automatic apply_reset();
    mem_ren = 1'b0; mem_wen = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete(); ovf_m = 1'b0; aerr_m = 1'b0; cyc_m = 32'h0;
  endtask

  task automatic test_reset();
    apply_reset();
    step(0, 0, 32'h10, 0, 0);
    checks++; if (obs_v !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", obs_v); end
    checks++; if (obs_ae !== 1'b0) begin errors++; $display("FAIL reset_aerr: got %b want 0", obs_ae); end
    checks++; if (obs_rd !== 32'h0) begin errors++; $display("FAIL reset_rdata_noren: got %h want 0", obs_rd); end
    step(1, 0, B + 4, 0, 0);
    checks++; if (obs_rd !== exp_rd) begin errors++; $display("FAIL reset_status: got %h want %h", obs_rd, exp_rd); end
  endtask

  task automatic test_ram();
    step(0, 1, 32'h10, 32'hDEADBEEF, 0);
    step(1, 0, 32'h10, 0, 0);
    checks++; if (obs_rd !== exp_rd) begin errors++; $display("FAIL ram_read: got %h want %h", obs_rd, exp_rd); end
    step(1, 1, 32'h10, 32'h55, 0);
    checks++; if (obs_rd !== exp_rd) begin errors++; $display("FAIL ram_rw_old: got %h want %h", obs_rd, exp_rd); end
    step(1, 0, 32'h10, 0, 0);
    checks++; if (obs_rd !== exp_rd) begin errors++; $display("FAIL ram_rw_new: got %h want %h", obs_rd, exp_rd); end
  endtask

  task automatic test_fifo_overflow();
    for (int i = 0; i < 5; i++) step(0, 1, B, 32'h1000 + i, 0);
    step(1, 0, B + 4, 0, 0);
    checks++; if (obs_rd !== exp_rd) begin errors++; $display("FAIL ovf_status: got %h want %h", obs_rd, exp_rd); end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1);
      checks++; if (obs_v !== exp_v || obs_d !== exp_d) begin
        errors++; $display("FAIL ovf_drain%0d: got %b/%h want %b/%h", i, obs_v, obs_d, exp_v, exp_d);
      end
    end
    step(0, 0, 0, 0, 0);
    checks++; if (obs_v !== exp_v) begin errors++; $display("FAIL ovf_empty_valid: got %b want %b", obs_v, exp_v); end
  endtask

  task automatic test_full_push_pop();
    step(0, 1, B + 4, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, B, 32'h2000 + i, 0);
    step(0, 1, B, 32'hA5, 1);
    checks++; if (obs_v !== exp_v || obs_d !== exp_d) begin
      errors++; $display("FAIL fpp_head: got %b/%h want %b/%h", obs_v, obs_d, exp_v, exp_d);
    end
    step(1, 0, B + 4, 0, 0);
    checks++; if (obs_rd !== exp_rd) begin errors++; $display("FAIL fpp_status: got %h want %h", obs_rd, exp_rd); end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1);
      checks++; if (obs_v !== exp_v || obs_d !== exp_d) begin
        errors++; $display("FAIL fpp_drain%0d: got %b/%h want %b/%h", i, obs_v, obs_d, exp_v, exp_d);
      end
    end
  endtask

  task automatic test_addr_err();
    step(1, 0, 32'h3, 0, 0);
    checks++; if (obs_rd !== exp_rd) begin errors++; $display("FAIL aerr_rdata: got %h want %h", obs_rd, exp_rd); end
    step(1, 0, B + 4, 0, 0);
    checks++; if (obs_ae !== exp_ae) begin errors++; $display("FAIL aerr_set: got %b want %b", obs_ae, exp_ae); end
    checks++; if (obs_rd !== exp_rd) begin errors++; $display("FAIL aerr_status: got %h want %h", obs_rd, exp_rd); end
    step(0, 1, B + 32'hC, 32'h77, 0);
    step(1, 0, B + 4, 0, 0);
    checks++; if (obs_rd !== exp_rd) begin errors++; $display("FAIL aerr_fifo_untouched: got %h want %h", obs_rd, exp_rd); end
    step(1, 0, 32'h10, 0, 0);
    checks++; if (obs_rd !== exp_rd || obs_ae !== exp_ae) begin
      errors++; $display("FAIL aerr_ram_untouched: got %h/%b want %h/%b", obs_rd, obs_ae, exp_rd, exp_ae);
    end
    apply_reset();
    step(0, 0, 0, 0, 0);
    checks++; if (obs_ae !== exp_ae) begin errors++; $display("FAIL aerr_clear: got %b want %b", obs_ae, exp_ae); end
  endtask

  task automatic test_cycle();
    apply_reset();
    for (int i = 0; i < 100; i++) step(0, 0, 0, 0, 0);
    step(1, 0, B + 8, 0, 0);
    checks++; if (obs_rd !== exp_rd) begin errors++; $display("FAIL cyc_100: got %h want %h", obs_rd, exp_rd); end
    step(0, 1, B + 8, 32'h1234, 0);
    step(1, 0, B + 8, 0, 0);
    checks++; if (obs_rd !== exp_rd) begin errors++; $display("FAIL cyc_clear: got %h want %h", obs_rd, exp_rd); end
    step(1, 0, B + 8, 0, 0);
    checks++; if (obs_rd !== exp_rd) begin errors++; $display("FAIL cyc_next: got %h want %h", obs_rd, exp_rd); end
    step(0, 0, 0, 0, 0);
    checks++; if (obs_ae !== exp_ae) begin errors++; $display("FAIL cyc_aerr: got %b want %b", obs_ae, exp_ae); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 3; i++) step(0, 1, B, 32'h3000 + i, 0);
    mem_wen = 1'b1; mem_addr = B; mem_wdata = 32'hBAD; out_ready = 1'b1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; mem_wen = 1'b0;
    exp_q.delete(); ovf_m = 1'b0; aerr_m = 1'b0; cyc_m = 32'h0;
    step(1, 0, B + 4, 0, 1);
    checks++; if (obs_v !== exp_v) begin errors++; $display("FAIL rmid_valid: got %b want %b", obs_v, exp_v); end
    checks++; if (obs_rd !== exp_rd) begin errors++; $display("FAIL rmid_status: got %h want %h", obs_rd, exp_rd); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic        r, w;
    int          sel;
    apply_reset();
    for (int i = 0; i < 16; i++) step(0, 1, 32'(i * 4), $urandom, 0);
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 9);
      r = 1'($urandom_range(0, 1));
      w = 1'b0;
      case (sel)
        0, 1, 2: begin a = 32'($urandom_range(0, 15) * 4); w = 1'($urandom_range(0, 1)); end
        3, 4:    begin a = B; w = 1'b1; r = 1'b0; end
        5:       begin a = B + 4; r = 1'b1; end
        6:       begin a = B + 4; w = 1'b1; end
        7:       begin a = B + 8; w = ($urandom_range(0, 3) == 0); end
        8:       begin
          a = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 3)) : B + 32'h10;
          if ($urandom_range(0, 7) != 0) begin r = 1'b0; w = 1'b0; end
        end
        default: begin a = 32'h0; r = 1'b0; end
      endcase
      step(r, w, a, $urandom, 1'($urandom_range(0, 1)));
      checks++; if (obs_rd !== exp_rd) begin errors++; $display("FAIL rnd_rdata@%0d: got %h want %h", n, obs_rd, exp_rd); end
      checks++; if (obs_v !== exp_v || (exp_v && obs_d !== exp_d)) begin
        errors++; $display("FAIL rnd_fifo@%0d: got %b/%h want %b/%h", n, obs_v, obs_d, exp_v, exp_d);
      end
      checks++; if (obs_ae !== exp_ae) begin errors++; $display("FAIL rnd_aerr@%0d: got %b want %b", n, obs_ae, exp_ae); end
    end
  endtask

  initial begin
    ovf_m = 1'b0; aerr_m = 1'b0; cyc_m = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_ram();
    test_fifo_overflow();
    test_full_push_pop();
    test_addr_err();
    test_cycle();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
